video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parametrised successor to the fixed 640x480 VGA controller.
- Generates horizontal/vertical timing from per-region parameters with selectable sync polarity.
- Issues registered pixel-fetch coordinates to a pixel source with configurable read latency, and re-aligns sync, DE and colour so all outputs leave on the same cycle.
- Sits between the pixel clock domain and the video DAC pins. Also provides frame/line strobes for the CPU-side video logic.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch, clocks
- H_SYNC, 96, hsync pulse width, clocks
- H_BP, 48, horizontal back porch, clocks
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch, lines
- V_SYNC, 2, vsync pulse width, lines
- V_BP, 29, vertical back porch, lines
- HS_POL, 0, hsync active level (0 = active low)
- VS_POL, 0, vsync active level
- PIPE_LAT, 1, clocks from fetch_h/fetch_v valid to pix_r/g/b valid (range 0..7)
- CW, 6, bits per colour channel

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- fetch_h  out  10  active-area column being fetched, 0..H_ACTIVE-1
- fetch_v  out  10  active-area row being fetched, 0..V_ACTIVE-1
- fetch_en  out  1  fetch_h/fetch_v address a visible pixel this cycle
- pix_r, pix_g, pix_b  in  CW each  pixel data, valid PIPE_LAT clocks after the matching fetch
- h_sync  out  1  horizontal sync, polarity HS_POL
- v_sync  out  1  vertical sync, polarity VS_POL
- de  out  1  display enable, aligned with red/green/blue
- red, green, blue  out  CW each  registered colour, forced 0 outside the active area
- line_start  out  1  one-clock pulse at hc==0, counter-aligned
- frame_start  out  1  one-clock pulse at hc==0 && vc==0, counter-aligned
- vblank  out  1  high while vc is outside the vertical active region, counter-aligned

Behaviour:
- Derived totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP; V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP. Defaults give 800 x 521.
- Line order is sync, back porch, active, front porch. The frame uses the same order.
- Counters:
  - hc counts 0..H_TOTAL-1, then wraps to 0.
  - vc increments only on an hc wrap and wraps to 0 after V_TOTAL-1.
  - Both are 10 bits; totals above 1024 are illegal.
- Region decode from the counters:
  - h_act = hc in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE)
  - v_act = vc in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE)
  - hs_raw = hc < H_SYNC
  - vs_raw = vc < V_SYNC
- Stage F (1 clock after the counters), all registered:
  - fetch_en = h_act && v_act
  - fetch_h = hc-(H_SYNC+H_BP) and fetch_v = vc-(V_SYNC+V_BP) when fetch_en, else 0.
- Delay line: hs_raw, vs_raw and fetch_en pass through a register chain of length PIPE_LAT+1 after stage F.
- Output stage:
  - h_sync = HS_POL ? hs_d : ~hs_d; v_sync likewise with VS_POL.
  - de = en_d.
  - red/green/blue = pix_* when en_d, else 0.
  - All of these are registered.
- Alignment:
  - The outputs for a given counter position appear PIPE_LAT+2 clocks after that counter value.
  - That is PIPE_LAT+1 clocks after the matching fetch_en.
- Strobes:
  - line_start, frame_start and vblank are registered from the counters, 1 clock late, and are not delayed further.
  - frame_start coincides with a line_start pulse.
- Reset (asynchronous assert, release synchronised by the clk edge):
  - hc = vc = 0; all delay stages cleared.
  - fetch_en = 0, fetch_h = fetch_v = 0, de = 0, red/green/blue = 0.
  - h_sync = ~HS_POL and v_sync = ~VS_POL (inactive level).
  - line_start = frame_start = 0, vblank = 0.
- After reset release:
  - The first rising edge moves hc to 1.
  - The first frame_start pulse appears the clock after release and represents hc=0, vc=0.
- Reset mid-frame: all outputs return to reset values immediately; the frame restarts from hc=0, vc=0. No partial DE burst may continue.
- pix_* are sampled only when en_d=1; X on pix_* while en_d=0 must not reach the outputs.
- PIPE_LAT=0: pix_* are sampled in the same cycle fetch_en is presented, delayed one register. The chain length is 1.

Test Plan:
- Defaults, PIPE_LAT=1, run 2 frames -> h_sync low for exactly 96 of every 800 clocks; v_sync low for 2x800 clocks per 521x800-clock frame; de high 640 clocks/line on 480 lines; 307200 de cycles per frame.
- Small config (H 4/1/2/1, V 3/1/1/1, PIPE_LAT=2), pixel source returns {fetch_v,fetch_h} after 2 clocks -> each de cycle carries the expected coordinate; first de appears 3 clocks after first fetch_en; line 0 column 0 = 0.
- Sweep PIPE_LAT 0..3 with HS_POL=1, VS_POL=1 -> sync pulses active high; distance from hsync rising edge to first de constant at H_BP+H_SYNC clocks in all configs.
- Drive pix_*=all ones constantly -> red/green/blue = 0 on every cycle where de=0, 63 where de=1.
- Assert rst_n low mid-active-line (hc=300, vc=100) for 3 clocks -> outputs immediately zero/inactive; after release frame_start pulses at clock 1; next de exactly (V_SYNC+V_BP)*H_TOTAL+H_SYNC+H_BP+PIPE_LAT+2 clocks later.
- Check strobes -> line_start pulses every 800 clocks; frame_start every 416800; vblank low for exactly 480 lines per frame.

Source files
------------

// File: rtl/video_timing_gen_if.sv
// Pixel-domain bundle between the timing generator, its pixel source and the DAC pins.
interface video_timing_gen_if #(
  parameter int CW = 6
);
  logic [9:0]    fetch_h;
  logic [9:0]    fetch_v;
  logic          fetch_en;
  logic [CW-1:0] pix_r;
  logic [CW-1:0] pix_g;
  logic [CW-1:0] pix_b;
  logic          h_sync;
  logic          v_sync;
  logic          de;
  logic [CW-1:0] red;
  logic [CW-1:0] green;
  logic [CW-1:0] blue;
  logic          line_start;
  logic          frame_start;
  logic          vblank;

  modport master (
    output fetch_h, fetch_v, fetch_en,
    output h_sync, v_sync, de, red, green, blue,
    output line_start, frame_start, vblank,
    input  pix_r, pix_g, pix_b
  );

  modport slave (
    input  fetch_h, fetch_v, fetch_en,
    input  h_sync, v_sync, de, red, green, blue,
    input  line_start, frame_start, vblank,
    output pix_r, pix_g, pix_b
  );
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: fetch addressing, latency-matched sync/DE/colour, CPU strobes.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 29,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIPE_LAT = 1,
  parameter int CW       = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  video_timing_gen_if.master vid
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_ACT_BEG = 10'(H_SYNC + H_BP);
  localparam logic [9:0]  V_ACT_BEG = 10'(V_SYNC + V_BP);
  localparam logic [10:0] H_BEG_W   = 11'(H_SYNC + H_BP);
  localparam logic [10:0] H_END_W   = 11'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [10:0] V_BEG_W   = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_END_W   = 11'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [10:0] HS_END_W  = 11'(H_SYNC);
  localparam logic [10:0] VS_END_W  = 11'(V_SYNC);
  localparam logic        HS_ON     = (HS_POL != 0);
  localparam logic        VS_ON     = (VS_POL != 0);

  typedef struct packed {
    logic hs;
    logic vs;
    logic en;
  } tap_t;

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       h_act, v_act, hs_raw, vs_raw;

  logic [9:0] fetch_h_q, fetch_h_d;
  logic [9:0] fetch_v_q, fetch_v_d;
  tap_t       stage_f;
  tap_t [PIPE_LAT:0] pipe_q, pipe_d;
  tap_t       tail;

  logic          h_sync_q, h_sync_d;
  logic          v_sync_q, v_sync_d;
  logic          de_q;
  logic [CW-1:0] red_q, red_d;
  logic [CW-1:0] green_q, green_d;
  logic [CW-1:0] blue_q, blue_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
  logic          vblank_q, vblank_d;

  always_comb begin
    hc_d = hc_q + 10'd1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
    end
  end

  always_comb begin
    h_act  = ({1'b0, hc_q} >= H_BEG_W) && ({1'b0, hc_q} < H_END_W);
    v_act  = ({1'b0, vc_q} >= V_BEG_W) && ({1'b0, vc_q} < V_END_W);
    hs_raw = {1'b0, hc_q} < HS_END_W;
    vs_raw = {1'b0, vc_q} < VS_END_W;

    stage_f.hs = hs_raw;
    stage_f.vs = vs_raw;
    stage_f.en = h_act && v_act;
    fetch_h_d  = stage_f.en ? hc_q - H_ACT_BEG : '0;
    fetch_v_d  = stage_f.en ? vc_q - V_ACT_BEG : '0;

    line_start_d  = (hc_q == '0);
    frame_start_d = (hc_q == '0) && (vc_q == '0);
    vblank_d      = ~v_act;
  end

  // Slot 0 is stage F itself; the tail feeds the output register, giving PIPE_LAT+1 stages after F.
  if (PIPE_LAT == 0) begin : g_no_delay
    assign pipe_d = stage_f;
  end else begin : g_delay
    assign pipe_d = {pipe_q[PIPE_LAT-1:0], stage_f};
  end

  assign tail = pipe_q[PIPE_LAT];

  always_comb begin
    h_sync_d = tail.hs ? HS_ON : ~HS_ON;
    v_sync_d = tail.vs ? VS_ON : ~VS_ON;
    red_d    = tail.en ? vid.pix_r : '0;
    green_d  = tail.en ? vid.pix_g : '0;
    blue_d   = tail.en ? vid.pix_b : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc_q          <= '0;
      vc_q          <= '0;
      fetch_h_q     <= '0;
      fetch_v_q     <= '0;
      pipe_q        <= '0;
      h_sync_q      <= ~HS_ON;
      v_sync_q      <= ~VS_ON;
      de_q          <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      vblank_q      <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      fetch_h_q     <= fetch_h_d;
      fetch_v_q     <= fetch_v_d;
      pipe_q        <= pipe_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      de_q          <= tail.en;
      red_q         <= red_d;
      green_q       <= green_d;
      blue_q        <= blue_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      vblank_q      <= vblank_d;
    end
  end

  assign vid.fetch_h     = fetch_h_q;
  assign vid.fetch_v     = fetch_v_q;
  assign vid.fetch_en    = pipe_q[0].en;
  assign vid.h_sync      = h_sync_q;
  assign vid.v_sync      = v_sync_q;
  assign vid.de          = de_q;
  assign vid.red         = red_q;
  assign vid.green       = green_q;
  assign vid.blue        = blue_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;
  assign vid.vblank      = vblank_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: several configurations run side by side against an arithmetic raster model.
module tb_video_timing_gen;

  localparam int NC = 5;
  localparam int CW = 6;
  localparam int HA [NC] = '{4, 10, 7, 16, 640};
  localparam int HF [NC] = '{1, 2, 3, 2, 16};
  localparam int HSY[NC] = '{2, 3, 1, 5, 96};
  localparam int HB [NC] = '{1, 4, 2, 3, 48};
  localparam int VA [NC] = '{3, 5, 4, 6, 480};
  localparam int VF [NC] = '{1, 1, 2, 1, 10};
  localparam int VSY[NC] = '{1, 2, 1, 2, 2};
  localparam int VB [NC] = '{1, 2, 3, 1, 29};
  localparam int HP [NC] = '{0, 1, 1, 0, 0};
  localparam int VP [NC] = '{0, 1, 0, 1, 0};
  localparam int LAT[NC] = '{2, 0, 1, 3, 1};

  typedef struct {
    logic       fen;
    logic [9:0] fh, fv;
    logic       hs, vs, de;
    logic [5:0] r, gc, b;
    logic       ls, fs, vb;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_edge;
  int   seed;
  bit   mode;
  int unsigned errors = 0;
  int unsigned checks = 0;

  logic       o_fen[NC], o_hs[NC], o_vs[NC], o_de[NC], o_ls[NC], o_fs[NC], o_vb[NC];
  logic [9:0] o_fh[NC], o_fv[NC];
  logic [5:0] o_r[NC], o_g[NC], o_b[NC];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) n_edge <= 0;
    else        n_edge <= n_edge + 1;
  end

  function automatic logic [5:0] pixc(int row, int col, int ch);
    if (mode) return '1;
    return 6'((row * 5 + col * 3 + ch * 17 + seed) & 63);
  endfunction

  for (genvar g = 0; g < NC; g++) begin : g_dut
    video_timing_gen_if #(.CW(CW)) vif ();

    video_timing_gen #(
      .H_ACTIVE(HA[g]), .H_FP(HF[g]), .H_SYNC(HSY[g]), .H_BP(HB[g]),
      .V_ACTIVE(VA[g]), .V_FP(VF[g]), .V_SYNC(VSY[g]), .V_BP(VB[g]),
      .HS_POL(HP[g]), .VS_POL(VP[g]), .PIPE_LAT(LAT[g]), .CW(CW)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .vid  (vif)
    );

    // Pixel source: returns data for the fetch presented LAT clocks earlier, X when that fetch was idle.
    logic [20:0] hist [0:3];
    logic [20:0] cur;
    always @(posedge clk) begin
      hist[0] <= {vif.fetch_en, vif.fetch_v, vif.fetch_h};
      for (int k = 1; k < 4; k++) hist[k] <= hist[k-1];
    end
    if (LAT[g] == 0) begin : g_l0
      assign cur = {vif.fetch_en, vif.fetch_v, vif.fetch_h};
    end else begin : g_ln
      assign cur = hist[LAT[g]-1];
    end
    always @(negedge clk) begin
      if (mode || cur[20] === 1'b1) begin
        vif.pix_r = pixc(int'(cur[19:10]), int'(cur[9:0]), 0);
        vif.pix_g = pixc(int'(cur[19:10]), int'(cur[9:0]), 1);
        vif.pix_b = pixc(int'(cur[19:10]), int'(cur[9:0]), 2);
      end else begin
        vif.pix_r = 'x;
        vif.pix_g = 'x;
        vif.pix_b = 'x;
      end
    end

    assign o_fen[g] = vif.fetch_en;
    assign o_fh[g]  = vif.fetch_h;
    assign o_fv[g]  = vif.fetch_v;
    assign o_hs[g]  = vif.h_sync;
    assign o_vs[g]  = vif.v_sync;
    assign o_de[g]  = vif.de;
    assign o_r[g]   = vif.red;
    assign o_g[g]   = vif.green;
    assign o_b[g]   = vif.blue;
    assign o_ls[g]  = vif.line_start;
    assign o_fs[g]  = vif.frame_start;
    assign o_vb[g]  = vif.vblank;
  end

  // Expected outputs n edges after reset release: strobes/fetch show raster position n-1,
  // video outputs show position n-2-LAT, earlier than that they hold reset values.
  function automatic exp_t model(int g, int n);
    exp_t e;
    int ht, vt, p, hc, vc;
    bit ha, va;
    ht = HSY[g] + HB[g] + HA[g] + HF[g];
    vt = VSY[g] + VB[g] + VA[g] + VF[g];
    e.fen = 0; e.fh = '0; e.fv = '0;
    e.hs = (HP[g] == 0); e.vs = (VP[g] == 0); e.de = 0;
    e.r = '0; e.gc = '0; e.b = '0;
    e.ls = 0; e.fs = 0; e.vb = 0;
    if (n > 0) begin
      p  = n - 1;
      hc = p % ht;
      vc = (p / ht) % vt;
      ha = (hc >= HSY[g] + HB[g]) && (hc < HSY[g] + HB[g] + HA[g]);
      va = (vc >= VSY[g] + VB[g]) && (vc < VSY[g] + VB[g] + VA[g]);
      e.ls  = (hc == 0);
      e.fs  = (hc == 0) && (vc == 0);
      e.vb  = !va;
      e.fen = ha && va;
      if (e.fen) begin
        e.fh = 10'(hc - HSY[g] - HB[g]);
        e.fv = 10'(vc - VSY[g] - VB[g]);
      end
    end
    p = n - 2 - LAT[g];
    if (p >= 0) begin
      hc = p % ht;
      vc = (p / ht) % vt;
      ha = (hc >= HSY[g] + HB[g]) && (hc < HSY[g] + HB[g] + HA[g]);
      va = (vc >= VSY[g] + VB[g]) && (vc < VSY[g] + VB[g] + VA[g]);
      e.hs = (hc < HSY[g]) ? (HP[g] != 0) : (HP[g] == 0);
      e.vs = (vc < VSY[g]) ? (VP[g] != 0) : (VP[g] == 0);
      e.de = ha && va;
      if (e.de) begin
        e.r  = pixc(vc - VSY[g] - VB[g], hc - HSY[g] - HB[g], 0);
        e.gc = pixc(vc - VSY[g] - VB[g], hc - HSY[g] - HB[g], 1);
        e.b  = pixc(vc - VSY[g] - VB[g], hc - HSY[g] - HB[g], 2);
      end
    end
    return e;
  endfunction

  task automatic do_reset(input bit new_mode);
    @(negedge clk);
    rst_n = 1'b0;
    mode  = new_mode;
    seed  = int'($urandom_range(0, 63));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    repeat (2) @(posedge clk);
    #1;
    for (int g = 0; g < NC; g++) begin
      e = model(g, 0);
      checks += 4;
      if ({o_fen[g], o_fv[g], o_fh[g]} !== {e.fen, e.fv, e.fh}) begin
        errors++; $display("FAIL reset_fetch cfg%0d got %h exp %h", g, {o_fen[g], o_fv[g], o_fh[g]}, {e.fen, e.fv, e.fh});
      end
      if ({o_hs[g], o_vs[g], o_de[g]} !== {e.hs, e.vs, e.de}) begin
        errors++; $display("FAIL reset_sync cfg%0d got %b exp %b", g, {o_hs[g], o_vs[g], o_de[g]}, {e.hs, e.vs, e.de});
      end
      if ({o_r[g], o_g[g], o_b[g]} !== {e.r, e.gc, e.b}) begin
        errors++; $display("FAIL reset_rgb cfg%0d got %h exp %h", g, {o_r[g], o_g[g], o_b[g]}, {e.r, e.gc, e.b});
      end
      if ({o_ls[g], o_fs[g], o_vb[g]} !== {e.ls, e.fs, e.vb}) begin
        errors++; $display("FAIL reset_strobe cfg%0d got %b exp %b", g, {o_ls[g], o_fs[g], o_vb[g]}, {e.ls, e.fs, e.vb});
      end
    end
  endtask

  task automatic test_stream(input int ncyc);
    exp_t e;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NC; g++) begin
        e = model(g, n_edge);
        checks += 4;
        if ({o_fen[g], o_fv[g], o_fh[g]} !== {e.fen, e.fv, e.fh}) begin
          errors++; $display("FAIL fetch cfg%0d n=%0d got %h exp %h", g, n_edge, {o_fen[g], o_fv[g], o_fh[g]}, {e.fen, e.fv, e.fh});
        end
        if ({o_hs[g], o_vs[g], o_de[g]} !== {e.hs, e.vs, e.de}) begin
          errors++; $display("FAIL sync_de cfg%0d n=%0d got %b exp %b", g, n_edge, {o_hs[g], o_vs[g], o_de[g]}, {e.hs, e.vs, e.de});
        end
        if ({o_r[g], o_g[g], o_b[g]} !== {e.r, e.gc, e.b}) begin
          errors++; $display("FAIL rgb cfg%0d n=%0d got %h exp %h", g, n_edge, {o_r[g], o_g[g], o_b[g]}, {e.r, e.gc, e.b});
        end
        if ({o_ls[g], o_fs[g], o_vb[g]} !== {e.ls, e.fs, e.vb}) begin
          errors++; $display("FAIL strobes cfg%0d n=%0d got %b exp %b", g, n_edge, {o_ls[g], o_fs[g], o_vb[g]}, {e.ls, e.fs, e.vb});
        end
      end
    end
  endtask

  // Two-frame totals and pulse spacing for the small configurations.
  task automatic test_counts();
    int hs_cnt[4], vs_cnt[4], de_cnt[4], act_cnt[4], ls_cnt[4], fs_cnt[4];
    int last_hs[4], last_ls[4], last_fs[4];
    logic prev_hs[4], prev_de[4];
    int ht, vt, fr, n;
    logic hs_on, vs_on;
    for (int g = 0; g < 4; g++) begin
      hs_cnt[g] = 0; vs_cnt[g] = 0; de_cnt[g] = 0; act_cnt[g] = 0; ls_cnt[g] = 0; fs_cnt[g] = 0;
      last_hs[g] = 0; last_ls[g] = 0; last_fs[g] = 0;
      prev_hs[g] = (HP[g] == 0); prev_de[g] = 1'b0;
    end
    do_reset(1'b0);
    for (int i = 0; i < 530; i++) begin
      @(posedge clk);
      #1;
      n = n_edge;
      for (int g = 0; g < 4; g++) begin
        ht = HSY[g] + HB[g] + HA[g] + HF[g];
        vt = VSY[g] + VB[g] + VA[g] + VF[g];
        fr = ht * vt;
        hs_on = (HP[g] != 0);
        vs_on = (VP[g] != 0);
        if (n >= LAT[g] + 2 && n < LAT[g] + 2 + 2 * fr) begin
          if (o_hs[g] === hs_on) hs_cnt[g]++;
          if (o_vs[g] === vs_on) vs_cnt[g]++;
          if (o_de[g] === 1'b1) de_cnt[g]++;
        end
        if (n >= 1 && n < 1 + 2 * fr) begin
          if (o_ls[g] === 1'b1) ls_cnt[g]++;
          if (o_fs[g] === 1'b1) fs_cnt[g]++;
          if (o_vb[g] === 1'b0) act_cnt[g]++;
        end
        if (o_hs[g] === hs_on && prev_hs[g] !== hs_on) last_hs[g] = n;
        if (o_de[g] === 1'b1 && prev_de[g] !== 1'b1 && last_hs[g] > 0) begin
          checks++;
          if (n - last_hs[g] != HSY[g] + HB[g]) begin
            errors++; $display("FAIL hs_to_de cfg%0d got %0d exp %0d", g, n - last_hs[g], HSY[g] + HB[g]);
          end
        end
        if (o_ls[g] === 1'b1) begin
          if (last_ls[g] > 0) begin
            checks++;
            if (n - last_ls[g] != ht) begin
              errors++; $display("FAIL ls_period cfg%0d got %0d exp %0d", g, n - last_ls[g], ht);
            end
          end
          last_ls[g] = n;
        end
        if (o_fs[g] === 1'b1) begin
          if (last_fs[g] > 0) begin
            checks++;
            if (n - last_fs[g] != fr) begin
              errors++; $display("FAIL fs_period cfg%0d got %0d exp %0d", g, n - last_fs[g], fr);
            end
          end
          last_fs[g] = n;
        end
        prev_hs[g] = o_hs[g];
        prev_de[g] = o_de[g];
      end
    end
    for (int g = 0; g < 4; g++) begin
      ht = HSY[g] + HB[g] + HA[g] + HF[g];
      vt = VSY[g] + VB[g] + VA[g] + VF[g];
      checks += 6;
      if (hs_cnt[g] != 2 * vt * HSY[g]) begin
        errors++; $display("FAIL hs_count cfg%0d got %0d exp %0d", g, hs_cnt[g], 2 * vt * HSY[g]);
      end
      if (vs_cnt[g] != 2 * VSY[g] * ht) begin
        errors++; $display("FAIL vs_count cfg%0d got %0d exp %0d", g, vs_cnt[g], 2 * VSY[g] * ht);
      end
      if (de_cnt[g] != 2 * VA[g] * HA[g]) begin
        errors++; $display("FAIL de_count cfg%0d got %0d exp %0d", g, de_cnt[g], 2 * VA[g] * HA[g]);
      end
      if (ls_cnt[g] != 2 * vt) begin
        errors++; $display("FAIL ls_count cfg%0d got %0d exp %0d", g, ls_cnt[g], 2 * vt);
      end
      if (fs_cnt[g] != 2) begin
        errors++; $display("FAIL fs_count cfg%0d got %0d exp 2", g, fs_cnt[g]);
      end
      if (act_cnt[g] != 2 * VA[g] * ht) begin
        errors++; $display("FAIL vblank_low cfg%0d got %0d exp %0d", g, act_cnt[g], 2 * VA[g] * ht);
      end
    end
  endtask

  task automatic test_all_ones();
    exp_t e;
    do_reset(1'b1);
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < NC; g++) begin
        e = model(g, n_edge);
        checks++;
        if ({o_de[g], o_r[g], o_g[g], o_b[g]} !== {e.de, e.r, e.gc, e.b}) begin
          errors++; $display("FAIL ones_rgb cfg%0d n=%0d got %h exp %h", g, n_edge, {o_de[g], o_r[g], o_g[g], o_b[g]}, {e.de, e.r, e.gc, e.b});
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    int first_de[NC];
    int want, ht;
    bit done;
    do_reset(1'b0);
    test_stream(40 + int'($urandom_range(0, 400)));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < NC; g++) begin
      e = model(g, 0);
      checks += 2;
      if ({o_fen[g], o_hs[g], o_vs[g], o_de[g], o_r[g], o_g[g], o_b[g]} !== {e.fen, e.hs, e.vs, e.de, e.r, e.gc, e.b}) begin
        errors++; $display("FAIL midrst_out cfg%0d got %h exp %h", g, {o_fen[g], o_hs[g], o_vs[g], o_de[g], o_r[g], o_g[g], o_b[g]}, {e.fen, e.hs, e.vs, e.de, e.r, e.gc, e.b});
      end
      if ({o_fh[g], o_fv[g], o_ls[g], o_fs[g], o_vb[g]} !== {e.fh, e.fv, e.ls, e.fs, e.vb}) begin
        errors++; $display("FAIL midrst_misc cfg%0d got %h exp %h", g, {o_fh[g], o_fv[g], o_ls[g], o_fs[g], o_vb[g]}, {e.fh, e.fv, e.ls, e.fs, e.vb});
      end
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int g = 0; g < NC; g++) begin
      first_de[g] = 0;
      checks++;
      if ({o_ls[g], o_fs[g]} !== 2'b11) begin
        errors++; $display("FAIL first_strobe cfg%0d got %b exp 11", g, {o_ls[g], o_fs[g]});
      end
    end
    done = 1'b0;
    for (int i = 0; i < 26000 && !done; i++) begin
      @(posedge clk);
      #1;
      done = 1'b1;
      for (int g = 0; g < NC; g++) begin
        if (first_de[g] == 0 && o_de[g] === 1'b1) first_de[g] = n_edge;
        if (first_de[g] == 0) done = 1'b0;
      end
    end
    for (int g = 0; g < NC; g++) begin
      ht   = HSY[g] + HB[g] + HA[g] + HF[g];
      want = (VSY[g] + VB[g]) * ht + HSY[g] + HB[g] + LAT[g] + 2;
      checks++;
      if (first_de[g] != want) begin
        errors++; $display("FAIL first_de cfg%0d got %0d exp %0d (0 = timeout)", g, first_de[g], want);
      end
    end
    test_stream(300);
  endtask

  initial begin
    rst_n = 1'b0;
    mode  = 1'b0;
    seed  = int'($urandom_range(0, 63));
    test_reset();
    do_reset(1'b0);
    test_stream(2600);
    test_counts();
    test_all_ones();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
